// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 datapath mux with valid/ready on both sides and a sticky out-of-range select flag.
// Optional feature: define MUX_SKID_EN to add a one-entry skid register that makes in_ready a flop output.
module mux_nto1_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // Out-of-range selects fall through the loop and yield zero.
  function automatic logic [WIDTH-1:0] pick(input logic [N_IN*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (s == SEL_W'(i)) begin
        r = d[i*WIDTH +: WIDTH];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic sel_bad(input logic [SEL_W-1:0] s);
    return (32'(s) >= 32'(N_IN));
  endfunction

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             accept_s;
  logic             take_s;

  assign take_s    = out_valid_q && out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  // Next state: a full skid entry drains to the output before anything new is accepted.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    sel_err_d    = sel_err_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (take_s) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = out_valid_q;
      end
    end else if (accept_s) begin
      if (out_valid_q && !out_ready) begin
        skid_data_d  = pick(in_data, in_sel);
        skid_valid_d = 1'b1;
      end else begin
        out_data_d   = pick(in_data, in_sel);
        out_valid_d  = 1'b1;
      end
      if (sel_bad(in_sel)) begin
        sel_err_d = 1'b1;
      end else begin
        sel_err_d = sel_err_q;
      end
    end else if (take_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sel_err_q    <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      sel_err_q    <= sel_err_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Next state: accept replaces the output (also covers accept-with-take), take alone empties it.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    if (accept_s) begin
      out_data_d  = pick(in_data, in_sel);
      out_valid_d = 1'b1;
      if (sel_bad(in_sel)) begin
        sel_err_d = 1'b1;
      end else begin
        sel_err_d = sel_err_q;
      end
    end else if (take_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: a 4-input and a 3-input instance share stimulus and are checked against a queue model.
module tb_mux_nto1_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready_a, out_valid_a, sel_err_a;
  logic [7:0] out_data_a;
  logic       in_ready_b, out_valid_b, sel_err_b;
  logic [7:0] out_data_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state per instance: m=0 is N_IN=4, m=1 is N_IN=3.
  int         cnt  [2] = '{0, 0};
  logic [7:0] ent0 [2] = '{8'h00, 8'h00};
  logic [7:0] ent1 [2] = '{8'h00, 8'h00};
  logic [7:0] disp [2] = '{8'h00, 8'h00};
  logic       err  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(8), .N_IN(4), .SEL_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .sel_err(sel_err_a)
  );

  mux_nto1_pipe #(.WIDTH(8), .N_IN(3), .SEL_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[23:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .sel_err(sel_err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int m);
`ifdef MUX_SKID_EN
    return cnt[m] < 2;
`else
    return (cnt[m] == 0) || out_ready;
`endif
  endfunction

  // Model: a FIFO of selected words; head is what out_data shows, capacity 1 (or 2 with skid).
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int         c;
      logic [7:0] e0, e1, d, v;
      logic       er, acc, take;
      int         n;
      c = cnt[m]; e0 = ent0[m]; e1 = ent1[m]; d = disp[m]; er = err[m];
      n = (m == 0) ? 4 : 3;
      if (!reset_n) begin
        c = 0; d = 8'h00; er = 1'b0;
      end else begin
        acc  = in_valid && exp_ready(m);
        take = (c > 0) && out_ready;
        if (take) begin
          e0 = e1;
          c  = c - 1;
        end
        if (acc) begin
          if (int'(in_sel) < n) begin
            v = in_data[in_sel*8 +: 8];
          end else begin
            v  = 8'h00;
            er = 1'b1;
          end
          if (c == 0) e0 = v; else e1 = v;
          c = c + 1;
        end
        if (c > 0) d = e0;
      end
      cnt[m] <= c; ent0[m] <= e0; ent1[m] <= e1; disp[m] <= d; err[m] <= er;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", {31'd0, out_valid_a}, {31'd0, cnt[0] > 0});
      chk("a_data",  {24'd0, out_data_a},  {24'd0, disp[0]});
      chk("a_err",   {31'd0, sel_err_a},   {31'd0, err[0]});
      chk("a_ready", {31'd0, in_ready_a},  {31'd0, exp_ready(0)});
      chk("b_valid", {31'd0, out_valid_b}, {31'd0, cnt[1] > 0});
      chk("b_data",  {24'd0, out_data_b},  {24'd0, disp[1]});
      chk("b_err",   {31'd0, sel_err_b},   {31'd0, err[1]});
      chk("b_ready", {31'd0, in_ready_b},  {31'd0, exp_ready(1)});
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [7:0] stream_exp [4];
    stream_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h44332211; out_ready = 1'b1;
    step(); step();
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_data",  {24'd0, out_data_a},  32'd0);
    chk("rst_err",   {31'd0, sel_err_b},   32'd0);
    chk("rst_ready", {31'd0, in_ready_a},  32'd1);

    in_sel = 2'd2; in_valid = 1'b1;
    step();
    chk("first_data",  {24'd0, out_data_a},  32'h33);
    chk("first_valid", {31'd0, out_valid_a}, 32'd1);
    chk("first_err",   {31'd0, sel_err_a},   32'd0);

    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      step();
      chk("stream_data",  {24'd0, out_data_a},  {24'd0, stream_exp[i]});
      chk("stream_valid", {31'd0, out_valid_a}, 32'd1);
    end
    chk("oor_data", {24'd0, out_data_b}, 32'd0);
    chk("oor_err",  {31'd0, sel_err_b},  32'd1);

    in_sel = 2'd0;
    step();
    chk("after_oor_data", {24'd0, out_data_b}, 32'h11);
    chk("after_oor_err",  {31'd0, sel_err_b},  32'd1);

    in_sel = 2'd1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data",  {24'd0, out_data_a},  32'h11);
      chk("stall_valid", {31'd0, out_valid_a}, 32'd1);
`ifndef MUX_SKID_EN
      chk("stall_ready", {31'd0, in_ready_a},  32'd0);
`endif
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
`ifndef MUX_SKID_EN
    chk("drain_valid", {31'd0, out_valid_a}, 32'd0);
    chk("drain_data",  {24'd0, out_data_a},  32'h11);
`endif

    in_valid = 1'b1; in_sel = 2'd2;
    step();
    out_ready = 1'b0; reset_n = 1'b0;
    step();
    chk("midrst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("midrst_data",  {24'd0, out_data_a},  32'd0);
    chk("midrst_err",   {31'd0, sel_err_b},   32'd0);
    reset_n = 1'b1; out_ready = 1'b1; in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      step();
      chk("idle_valid", {31'd0, out_valid_b}, 32'd0);
      chk("idle_err",   {31'd0, sel_err_b},   32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      in_data   = $urandom;
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset_n   = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
